uart_hex_loader: RTL and testbench

//  Parametrised ASCII-hex program loader between the UART byte interface and an instruction/data RAM.
//  - Parses received hex digits, upper or lower case, MSB nibble first, into WORD_W-bit words.
//  - Writes each completed word to sequential addresses and echoes every accepted byte.
//  - Keeps a running checksum and transmits it as hex on request.
//  - Replaces the fixed 32-bit x 16 loader; adds address reset, end-of-load, error and checksum report.

---
 rtl/uart_loader_pkg.sv | 43 ++++
 rtl/ascii_hex_codec.sv | 17 +
 rtl/uart_hex_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_hex_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared ASCII constants, loader FSM states and hex conversion helpers
// used by the UART hex loader and its codec.
package uart_loader_pkg;

    localparam logic [7:0] CH_AT   = 8'h40;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_QM   = 8'h3F;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ECHO   = 3'd1,
        ST_REPORT = 3'd2,
        ST_CR     = 3'd3,
        ST_LF     = 3'd4
    } loader_state_t;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters of either case carry value-9 in their low nibble.
    function automatic logic [3:0] hex2nib(input logic [7:0] b);
        if (b <= 8'h39) begin
            return b[3:0];
        end else begin
            return b[3:0] + 4'd9;
        end
    endfunction

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return {4'h3, n};
        end else begin
            return 8'h37 + {4'h0, n};
        end
    endfunction

endpackage

// File: rtl/ascii_hex_codec.sv
// Combinational ASCII hex codec: received byte -> {valid, nibble} and
// nibble -> uppercase ASCII character for the checksum report.
module ascii_hex_codec
    import uart_loader_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic [3:0] o_nib,
    input  logic [3:0] i_nib,
    output logic [7:0] o_ascii
);

    assign o_is_hex = is_hex(i_byte);
    assign o_nib    = hex2nib(i_byte);
    assign o_ascii  = nib2ascii(i_nib);

endmodule

// File: rtl/uart_hex_loader.sv
// ASCII-hex program loader: assembles hex digits from the UART into words,
// writes them to sequential RAM addresses, echoes input and reports a checksum.
module uart_hex_loader
    import uart_loader_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ECHO_EN  = 1,
    parameter int OVF_WRAP = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_load_done,
    output logic              o_err_flag,
    output logic              o_busy
);

    localparam int NIBS  = WORD_W / 4;
    localparam int IDX_W = $clog2(NIBS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NIBS - 1);
    localparam logic [ADDR_W:0]   WC_FULL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    loader_state_t     r_state;
    logic [WORD_W-5:0] r_shreg;
    logic [IDX_W-1:0]  r_nib_cnt;
    logic [IDX_W-1:0]  r_rep_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count;
    logic [WORD_W-1:0] r_checksum;
    logic              r_qm;
    logic              r_rx_ready;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              r_load_done;
    logic              r_err;
    logic              r_busy;

    logic              w_acc;
    logic              w_is_hex;
    logic [3:0]        w_nib;
    logic [WORD_W-1:0] w_word;
    logic              w_full;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [3:0]        w_rep_nib;
    logic [7:0]        w_ascii;

    ascii_hex_codec u_codec (
        .i_byte   (i_rx_data),
        .o_is_hex (w_is_hex),
        .o_nib    (w_nib),
        .i_nib    (w_rep_nib),
        .o_ascii  (w_ascii)
    );

    assign w_acc      = i_rx_valid & r_rx_ready;
    assign w_word     = {r_shreg, w_nib};
    assign w_full     = (r_word_count == WC_FULL);
    assign w_addr_nxt = (r_addr == ADDR_LAST) ? {ADDR_W{1'b0}} : r_addr + ADDR_W'(1);

    // Select the checksum nibble that the next report byte will carry.
    always_comb begin
        w_sel_idx = {IDX_W{1'b0}};
        w_rep_nib = 4'h0;
        if (r_state == ST_REPORT) begin
            w_sel_idx = r_rep_idx + IDX_W'(1);
        end else begin
            w_sel_idx = {IDX_W{1'b0}};
        end
        for (int i = 0; i < NIBS; i++) begin
            w_rep_nib = w_rep_nib |
                ((w_sel_idx == IDX_W'(i)) ? r_checksum[WORD_W-4-4*i +: 4] : 4'h0);
        end
    end

    // Loader FSM, word assembly, address/count/checksum and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= {(WORD_W-4){1'b0}};
            r_nib_cnt    <= {IDX_W{1'b0}};
            r_rep_idx    <= {IDX_W{1'b0}};
            r_addr       <= {ADDR_W{1'b0}};
            r_word_count <= {(ADDR_W+1){1'b0}};
            r_checksum   <= {WORD_W{1'b0}};
            r_qm         <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_wdata  <= {WORD_W{1'b0}};
            r_load_done  <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rx_ready <= 1'b1;
                    if (w_acc) begin
                        if (w_is_hex) begin
                            r_shreg <= w_word[WORD_W-5:0];
                            if (r_nib_cnt == LAST_IDX) begin
                                r_nib_cnt <= {IDX_W{1'b0}};
                                if (w_full && (OVF_WRAP == 0)) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_mem_we     <= 1'b1;
                                    r_mem_addr   <= r_addr;
                                    r_mem_wdata  <= w_word;
                                    r_addr       <= w_addr_nxt;
                                    r_checksum   <= r_checksum + w_word;
                                    if (!w_full) begin
                                        r_word_count <= r_word_count + (ADDR_W+1)'(1);
                                    end
                                end
                            end else begin
                                r_nib_cnt <= r_nib_cnt + IDX_W'(1);
                            end
                        end else if (i_rx_data == CH_AT) begin
                            r_addr       <= {ADDR_W{1'b0}};
                            r_shreg      <= {(WORD_W-4){1'b0}};
                            r_nib_cnt    <= {IDX_W{1'b0}};
                            r_checksum   <= {WORD_W{1'b0}};
                            r_word_count <= {(ADDR_W+1){1'b0}};
                            r_load_done  <= 1'b0;
                            r_err        <= 1'b0;
                        end else if (i_rx_data == CH_HASH) begin
                            r_load_done <= 1'b1;
                            if (r_nib_cnt != {IDX_W{1'b0}}) begin
                                r_nib_cnt <= {IDX_W{1'b0}};
                                r_err     <= 1'b1;
                            end
                        end else if ((i_rx_data != CH_QM) && (i_rx_data != CH_SP) &&
                                     (i_rx_data != CH_CR) && (i_rx_data != CH_LF)) begin
                            r_err <= 1'b1;
                        end

                        if (ECHO_EN != 0) begin
                            r_state    <= ST_ECHO;
                            r_tx_data  <= i_rx_data;
                            r_tx_valid <= 1'b1;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_qm       <= (i_rx_data == CH_QM);
                        end else if (i_rx_data == CH_QM) begin
                            r_state    <= ST_REPORT;
                            r_rep_idx  <= {IDX_W{1'b0}};
                            r_tx_data  <= w_ascii;
                            r_tx_valid <= 1'b1;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_ECHO: begin
                    if (i_tx_ready) begin
                        if (r_qm) begin
                            r_state   <= ST_REPORT;
                            r_rep_idx <= {IDX_W{1'b0}};
                            r_tx_data <= w_ascii;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                ST_REPORT: begin
                    if (i_tx_ready) begin
                        if (r_rep_idx == LAST_IDX) begin
                            r_state   <= ST_CR;
                            r_tx_data <= CH_CR;
                        end else begin
                            r_rep_idx <= r_rep_idx + IDX_W'(1);
                            r_tx_data <= w_ascii;
                        end
                    end
                end
                ST_CR: begin
                    if (i_tx_ready) begin
                        r_state   <= ST_LF;
                        r_tx_data <= CH_LF;
                    end
                end
                ST_LF: begin
                    if (i_tx_ready) begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                    r_rx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_ready   = r_rx_ready;
    assign o_tx_data    = r_tx_data;
    assign o_tx_valid   = r_tx_valid;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_word_count = r_word_count;
    assign o_load_done  = r_load_done;
    assign o_err_flag   = r_err;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: four instances cover the default
// configuration, DEPTH=4 overflow drop/wrap and a 16-bit no-echo build.
module tb_uart_hex_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic tx_ready = 1'b1;
    logic [3:0] rxv = 4'b0000;

    logic [3:0] rxr, txv, we, ld, ef, bz;
    logic [3:0][7:0] txd;
    logic [3:0]  a0, a3;
    logic [1:0]  a1, a2;
    logic [31:0] d0, d1, d2;
    logic [15:0] d3;
    logic [4:0]  c0, c3;
    logic [2:0]  c1, c2;
    logic [3:0][7:0]  addr_w;
    logic [3:0][31:0] data_w;
    logic [3:0][7:0]  wc_w;

    int checks = 0;
    int failures = 0;

    typedef struct packed {logic [1:0] dut; logic [7:0] addr; logic [31:0] data;} wr_t;
    typedef struct packed {logic [1:0] dut; logic [7:0] b;} tx_t;
    wr_t exp_wr[$];
    tx_t exp_tx[$];

    logic [3:0] pv = 4'b0000;
    logic [3:0][7:0] pd;

    always #5 clk = ~clk;

    uart_hex_loader u0 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rxv[0]), .o_rx_ready(rxr[0]),
        .o_tx_data(txd[0]), .o_tx_valid(txv[0]), .i_tx_ready(tx_ready), .o_mem_we(we[0]),
        .o_mem_addr(a0), .o_mem_wdata(d0), .o_word_count(c0), .o_load_done(ld[0]),
        .o_err_flag(ef[0]), .o_busy(bz[0]));

    uart_hex_loader #(.DEPTH(4), .OVF_WRAP(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rxv[1]), .o_rx_ready(rxr[1]),
        .o_tx_data(txd[1]), .o_tx_valid(txv[1]), .i_tx_ready(tx_ready), .o_mem_we(we[1]),
        .o_mem_addr(a1), .o_mem_wdata(d1), .o_word_count(c1), .o_load_done(ld[1]),
        .o_err_flag(ef[1]), .o_busy(bz[1]));

    uart_hex_loader #(.DEPTH(4), .OVF_WRAP(1)) u2 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rxv[2]), .o_rx_ready(rxr[2]),
        .o_tx_data(txd[2]), .o_tx_valid(txv[2]), .i_tx_ready(tx_ready), .o_mem_we(we[2]),
        .o_mem_addr(a2), .o_mem_wdata(d2), .o_word_count(c2), .o_load_done(ld[2]),
        .o_err_flag(ef[2]), .o_busy(bz[2]));

    uart_hex_loader #(.WORD_W(16), .ECHO_EN(0)) u3 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rxv[3]), .o_rx_ready(rxr[3]),
        .o_tx_data(txd[3]), .o_tx_valid(txv[3]), .i_tx_ready(tx_ready), .o_mem_we(we[3]),
        .o_mem_addr(a3), .o_mem_wdata(d3), .o_word_count(c3), .o_load_done(ld[3]),
        .o_err_flag(ef[3]), .o_busy(bz[3]));

    always_comb begin
        addr_w = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        data_w = {32'(d3), d2, d1, d0};
        wc_w   = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    end

    // Monitor: pops expected writes/tx bytes and checks tx hold during stalls.
    always @(negedge clk) begin : monitor
        wr_t w;
        tx_t t;
        if (rst) begin
            pv <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    checks++;
                    if (exp_wr.size() == 0) begin
                        failures++;
                        $display("FAIL wr_unexpected dut%0d: got addr=%h data=%h, required no write", k, addr_w[k], data_w[k]);
                    end else begin
                        w = exp_wr.pop_front();
                        if (w.dut !== 2'(k) || w.addr !== addr_w[k] || w.data !== data_w[k]) begin
                            failures++;
                            $display("FAIL wr dut%0d: got addr=%h data=%h, required dut%0d addr=%h data=%h",
                                     k, addr_w[k], data_w[k], w.dut, w.addr, w.data);
                        end
                    end
                end
                if (txv[k] && tx_ready) begin
                    checks++;
                    if (exp_tx.size() == 0) begin
                        failures++;
                        $display("FAIL tx_unexpected dut%0d: got %h, required no tx", k, txd[k]);
                    end else begin
                        t = exp_tx.pop_front();
                        if (t.dut !== 2'(k) || t.b !== txd[k]) begin
                            failures++;
                            $display("FAIL tx dut%0d: got %h, required dut%0d byte %h", k, txd[k], t.dut, t.b);
                        end
                    end
                end
                if (pv[k]) begin
                    checks++;
                    if (!txv[k] || txd[k] !== pd[k]) begin
                        failures++;
                        $display("FAIL tx_hold dut%0d: got valid=%b data=%h, required valid=1 data=%h", k, txv[k], txd[k], pd[k]);
                    end
                end
            end
            pv <= txv & {4{~tx_ready}};
            pd <= txd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int k, input int addr, input logic [31:0] data);
        wr_t w;
        w.dut = 2'(k); w.addr = 8'(addr); w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic push_tx(input int k, input logic [7:0] b);
        tx_t t;
        t.dut = 2'(k); t.b = b;
        exp_tx.push_back(t);
    endtask

    task automatic push_report(input int k, input logic [31:0] v, input int nibs);
        logic [3:0] n;
        for (int i = nibs - 1; i >= 0; i--) begin
            n = v[4*i +: 4];
            push_tx(k, (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n)));
        end
        push_tx(k, 8'h0D);
        push_tx(k, 8'h0A);
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        int t = 0;
        while (!rxr[k] && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout dut%0d: got rx_ready=0, required 1 within 100 cycles", k);
        end
        if (k != 3) push_tx(k, b);
        rx_data = b;
        rxv[k] = 1'b1;
        tick();
        rxv[k] = 1'b0;
    endtask

    task automatic send_str(input int k, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(k, s[i]);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && t < 1000) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 1000) begin
            failures++;
            $display("FAIL drain: got tx_left=%0d wr_left=%0d, required 0", exp_tx.size(), exp_wr.size());
            exp_tx.delete();
            exp_wr.delete();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({rxr[k], txv[k], we[k], ld[k], ef[k], bz[k]} !== 6'b0 || txd[k] !== 8'h00 ||
                addr_w[k] !== 8'h00 || data_w[k] !== 32'h0 || wc_w[k] !== 8'h00) begin
                failures++;
                $display("FAIL reset dut%0d: got flags=%b tx=%h wc=%h, required all 0", k,
                         {rxr[k], txv[k], we[k], ld[k], ef[k], bz[k]}, txd[k], wc_w[k]);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rxr !== 4'hF) begin
            failures++;
            $display("FAIL reset_ready: got %b, required 1111", rxr);
        end
    endtask

    task automatic test_basic();
        push_wr(0, 0, 32'hDEADBEEF);
        send_str(0, "DEADBEEF");
        drain();
        checks++;
        if (wc_w[0] !== 8'd1 || ef[0] !== 1'b0) begin
            failures++;
            $display("FAIL basic_count: got wc=%0d err=%b, required wc=1 err=0", wc_w[0], ef[0]);
        end
    endtask

    task automatic test_error_partial();
        send_byte(0, "@");
        push_wr(0, 0, 32'h00000013);
        send_str(0, "00000013");
        send_byte(0, "x");
        checks++;
        if (ef[0] !== 1'b1) begin
            failures++;
            $display("FAIL bad_char_err: got %b, required 1", ef[0]);
        end
        send_str(0, "0000093");
        drain();
        send_byte(0, "#");
        drain();
        checks++;
        if (ld[0] !== 1'b1 || ef[0] !== 1'b1 || wc_w[0] !== 8'd1) begin
            failures++;
            $display("FAIL hash_partial: got done=%b err=%b wc=%0d, required done=1 err=1 wc=1", ld[0], ef[0], wc_w[0]);
        end
        push_wr(0, 1, 32'h0000000A);
        send_str(0, "0000000a");
        drain();
        checks++;
        if (ld[0] !== 1'b1 || wc_w[0] !== 8'd2) begin
            failures++;
            $display("FAIL after_done: got done=%b wc=%0d, required done=1 wc=2", ld[0], wc_w[0]);
        end
    endtask

    task automatic test_report();
        send_byte(0, "@");
        push_wr(0, 0, 32'h1);
        send_str(0, "00000001");
        push_wr(0, 1, 32'h2);
        send_str(0, "00000002");
        send_byte(0, "?");
        push_report(0, 32'h00000003, 8);
        tick(); tick(); tick(); tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rxr[0] !== 1'b0 || bz[0] !== 1'b1 || txv[0] !== 1'b1) begin
                failures++;
                $display("FAIL stall: got rx_ready=%b busy=%b tx_valid=%b, required 0 1 1", rxr[0], bz[0], txv[0]);
            end
        end
        tx_ready = 1'b1;
        drain();
        checks++;
        if (rxr[0] !== 1'b1 || bz[0] !== 1'b0 || txv[0] !== 1'b0) begin
            failures++;
            $display("FAIL report_end: got rx_ready=%b busy=%b tx_valid=%b, required 1 0 0", rxr[0], bz[0], txv[0]);
        end
    endtask

    task automatic test_clear();
        send_str(0, "12AB");
        send_byte(0, "@");
        push_wr(0, 0, 32'hFFFFFFFF);
        send_str(0, "ffffffff");
        send_byte(0, "?");
        push_report(0, 32'hFFFFFFFF, 8);
        drain();
        checks++;
        if (wc_w[0] !== 8'd1 || ld[0] !== 1'b0 || ef[0] !== 1'b0) begin
            failures++;
            $display("FAIL clear: got wc=%0d done=%b err=%b, required wc=1 done=0 err=0", wc_w[0], ld[0], ef[0]);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 2; k++) begin
            for (int w = 1; w <= 5; w++) begin
                if (w <= 4) push_wr(k, w - 1, 32'(w));
                else if (k == 2) push_wr(k, 0, 32'(w));
                send_str(k, $sformatf("%08x", w));
            end
            drain();
        end
        checks++;
        if (ef[1] !== 1'b1 || wc_w[1] !== 8'd4) begin
            failures++;
            $display("FAIL ovf_drop: got err=%b wc=%0d, required err=1 wc=4", ef[1], wc_w[1]);
        end
        checks++;
        if (ef[2] !== 1'b0 || wc_w[2] !== 8'd4) begin
            failures++;
            $display("FAIL ovf_wrap: got err=%b wc=%0d, required err=0 wc=4", ef[2], wc_w[2]);
        end
    endtask

    task automatic test_no_echo_reset();
        push_wr(3, 0, 32'h00001A2B);
        send_str(3, "1a2B");
        tick(); tick();
        checks++;
        if (txv[3] !== 1'b0 || wc_w[3] !== 8'd1 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL no_echo: got tx_valid=%b wc=%0d pending=%0d, required 0 1 0", txv[3], wc_w[3], exp_wr.size());
        end
        tx_ready = 1'b0;
        send_byte(3, "?");
        tick();
        checks++;
        if (txv[3] !== 1'b1 || txd[3] !== 8'h31 || bz[3] !== 1'b1) begin
            failures++;
            $display("FAIL report_start: got valid=%b data=%h busy=%b, required 1 31 1", txv[3], txd[3], bz[3]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({rxr[3], txv[3], we[3], ld[3], ef[3], bz[3]} !== 6'b0 || wc_w[3] !== 8'h00 || txd[3] !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: got flags=%b tx=%h wc=%0d, required all 0",
                     {rxr[3], txv[3], we[3], ld[3], ef[3], bz[3]}, txd[3], wc_w[3]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rxr[3] !== 1'b1 || txv[3] !== 1'b0 || bz[3] !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: got rx_ready=%b tx_valid=%b busy=%b, required 1 0 0", rxr[3], txv[3], bz[3]);
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error_partial();
        test_report();
        test_clear();
        test_overflow();
        test_no_echo_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
